// File: rtl/clock_ui_pkg.sv
// clock_ui_pkg
//   Shared types and helpers for the front-panel controller.
//   - ui_mode_t   : mode code presented on ui_mode (6 and 7 are never produced)
//   - FLD_*       : field codes presented on ui_field
//   - BTN_*       : bit positions of the buttons inside the internal press vector
//   - ui_pulse_t  : bundle of every one-cycle command pulse
//   - is_set_mode / next_mode / next_field : mode and field stepping rules
package clock_ui_pkg;

    typedef enum logic [2:0] {
        MODE_CLOCK     = 3'd0,
        MODE_SET_TIME  = 3'd1,
        MODE_SET_ALARM = 3'd2,
        MODE_STOPWATCH = 3'd3,
        MODE_TIMER     = 3'd4,
        MODE_SET_TIMER = 3'd5
    } ui_mode_t;

    localparam logic [1:0] FLD_HOURS   = 2'd0;
    localparam logic [1:0] FLD_MINUTES = 2'd1;
    localparam logic [1:0] FLD_SECONDS = 2'd2;

    localparam int NUM_BUTTONS = 5;
    localparam int BTN_MODE    = 0;
    localparam int BTN_SEL     = 1;
    localparam int BTN_UP      = 2;
    localparam int BTN_GO      = 3;
    localparam int BTN_CLR     = 4;

    typedef struct packed {
        logic alarm_reset;
        logic reset_timer;
        logic stop_timer;
        logic start_timer;
        logic reset_stopwatch;
        logic stop_stopwatch;
        logic start_stopwatch;
        logic inc_timer_seconds;
        logic inc_timer_minutes;
        logic inc_timer_hours;
        logic inc_alarm_minutes;
        logic inc_alarm_hours;
        logic inc_seconds;
        logic inc_minutes;
        logic inc_hours;
    } ui_pulse_t;

    function automatic logic is_set_mode(input ui_mode_t m);
        return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM) || (m == MODE_SET_TIMER);
    endfunction

    function automatic ui_mode_t next_mode(input ui_mode_t m);
        case (m)
            MODE_CLOCK:     return MODE_SET_TIME;
            MODE_SET_TIME:  return MODE_SET_ALARM;
            MODE_SET_ALARM: return MODE_STOPWATCH;
            MODE_STOPWATCH: return MODE_TIMER;
            MODE_TIMER:     return MODE_SET_TIMER;
            default:        return MODE_CLOCK;
        endcase
    endfunction

    // The alarm has no seconds field, so it only toggles hours/minutes.
    function automatic logic [1:0] next_field(input ui_mode_t m, input logic [1:0] f);
        if (m == MODE_SET_ALARM) begin
            return (f == FLD_HOURS) ? FLD_MINUTES : FLD_HOURS;
        end
        return (f >= FLD_SECONDS) ? FLD_HOURS : f + 2'd1;
    endfunction

endpackage

// File: rtl/clock_ui_ctrl_btn_sync_edge.sv
// btn_sync_edge
//   Two-flop synchroniser for one raw push button followed by a rising-edge
//   detector against the previous synchronised sample.
//   Ports:
//     clk_1Hz  in   tick clock
//     reset    in   asynchronous, active-high
//     btn_raw  in   raw pad level
//     press    out  one-cycle pulse on each synchronised 0->1 transition
//     held     out  synchronised level (used for hold/auto-repeat)
module btn_sync_edge (
    input  logic clk_1Hz,
    input  logic reset,
    input  logic btn_raw,
    output logic press,
    output logic held
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev;
    assign held  = sync2;

endmodule

// File: rtl/clock_ui_ctrl.sv
// clock_ui_ctrl
//   Front-panel controller: turns five push buttons into mode selects and
//   one-cycle command pulses for the timekeeping core.
//   Optional build macro: CLOCK_UI_AUTO_REPEAT_EN (auto-repeat on held btn_up).
//   Ports:
//     clk_1Hz, reset (async, active-high)
//     btn_mode/btn_sel/btn_up/btn_go/btn_clr   raw buttons
//     is_stopwatch_running/is_timer_running/alarm_trigger   core status
//     *_mode            registered one-hot-or-zero mode levels
//     inc_*/start_*/stop_*/reset_*/alarm_reset  registered one-cycle pulses
//     ui_mode (3b)      current mode code (also the FSM state for debug)
//     ui_field (2b)     selected field 0=hours 1=minutes 2=seconds
//   Latency: a raw rising edge sampled at edge N acts after edge N+2.
module clock_ui_ctrl
    import clock_ui_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 30,
    parameter int HOLD_DLY     = 2
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_up,
    input  logic       btn_go,
    input  logic       btn_clr,
    input  logic       is_stopwatch_running,
    input  logic       is_timer_running,
    input  logic       alarm_trigger,
    output logic       set_time_mode,
    output logic       set_alarm_mode,
    output logic       stopwatch_mode,
    output logic       timer_mode,
    output logic       set_timer_mode,
    output logic       inc_hours,
    output logic       inc_minutes,
    output logic       inc_seconds,
    output logic       inc_alarm_hours,
    output logic       inc_alarm_minutes,
    output logic       inc_timer_hours,
    output logic       inc_timer_minutes,
    output logic       inc_timer_seconds,
    output logic       start_stopwatch,
    output logic       stop_stopwatch,
    output logic       reset_stopwatch,
    output logic       start_timer,
    output logic       stop_timer,
    output logic       reset_timer,
    output logic       alarm_reset,
    output logic [2:0] ui_mode,
    output logic [1:0] ui_field
);

    localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] press;
    logic [NUM_BUTTONS-1:0] held;
    logic                   up_rep;
    logic                   up_evt;
    logic                   any_press;
    logic                   unused_held;

    ui_mode_t         mode_q, mode_d;
    logic [1:0]       field_q, field_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    ui_pulse_t        pulse_q, pulse_d;
    logic [4:0]       lvl_q, lvl_d;

    assign btn_raw = {btn_clr, btn_go, btn_up, btn_sel, btn_mode};

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
        btn_sync_edge u_sync (
            .clk_1Hz (clk_1Hz),
            .reset   (reset),
            .btn_raw (btn_raw[gi]),
            .press   (press[gi]),
            .held    (held[gi])
        );
    end

`ifdef CLOCK_UI_AUTO_REPEAT_EN
    localparam int HOLD_W = (HOLD_DLY > 0) ? $clog2(HOLD_DLY + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_DLY);

    // hold_q counts cycles since the initial press while btn_up stays held,
    // saturating at HOLD_LIM; from then on every held cycle repeats.
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        up_rep = 1'b0;
        if (press[BTN_UP]) begin
            hold_d = HOLD_W'(1);
        end else if (held[BTN_UP]) begin
            up_rep = (hold_q >= HOLD_LIM);
            if (hold_q < HOLD_LIM) hold_d = hold_q + HOLD_W'(1);
        end else begin
            hold_d = '0;
        end
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`else
    assign up_rep = 1'b0;
`endif

    // Held levels only matter for auto-repeat.
    assign unused_held = (^held) ^ (HOLD_DLY != 0);

    assign up_evt    = press[BTN_UP] | up_rep;
    assign any_press = (|press) | up_rep;

    // State register (mode/field/idle counter) plus registered outputs.
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_CLOCK;
            field_q <= FLD_HOURS;
            idle_q  <= '0;
            pulse_q <= '0;
            lvl_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            field_q <= field_d;
            idle_q  <= idle_d;
            pulse_q <= pulse_d;
            lvl_q   <= lvl_d;
        end
    end

    // Next state: btn_mode wins outright; otherwise sel, then idle timeout.
    always_comb begin
        mode_d  = mode_q;
        field_d = field_q;
        idle_d  = idle_q;
        if (press[BTN_MODE]) begin
            mode_d  = next_mode(mode_q);
            field_d = FLD_HOURS;
            idle_d  = '0;
        end else begin
            if (press[BTN_SEL]) field_d = next_field(mode_q, field_q);
            if (!is_set_mode(mode_q) || (IDLE_TIMEOUT == 0) || any_press) begin
                idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
                mode_d  = MODE_CLOCK;
                field_d = FLD_HOURS;
                idle_d  = '0;
            end else if (idle_q != '1) begin
                idle_d = idle_q + CNT_W'(1);
            end
        end
    end

    // Output decode. Increments use field_d so a same-cycle sel retargets up.
    always_comb begin
        pulse_d = '0;
        lvl_d   = '0;
        if (!press[BTN_MODE]) begin
            if (up_evt) begin
                case (mode_q)
                    MODE_SET_TIME: begin
                        pulse_d.inc_hours   = (field_d == FLD_HOURS);
                        pulse_d.inc_minutes = (field_d == FLD_MINUTES);
                        pulse_d.inc_seconds = (field_d == FLD_SECONDS);
                    end
                    MODE_SET_ALARM: begin
                        pulse_d.inc_alarm_hours   = (field_d == FLD_HOURS);
                        pulse_d.inc_alarm_minutes = (field_d == FLD_MINUTES);
                    end
                    MODE_SET_TIMER: begin
                        pulse_d.inc_timer_hours   = (field_d == FLD_HOURS);
                        pulse_d.inc_timer_minutes = (field_d == FLD_MINUTES);
                        pulse_d.inc_timer_seconds = (field_d == FLD_SECONDS);
                    end
                    default: ;
                endcase
            end
            if (press[BTN_GO]) begin
                if (mode_q == MODE_STOPWATCH) begin
                    pulse_d.start_stopwatch = !is_stopwatch_running;
                    pulse_d.stop_stopwatch  = is_stopwatch_running;
                end else if (mode_q == MODE_TIMER) begin
                    pulse_d.start_timer = !is_timer_running;
                    pulse_d.stop_timer  = is_timer_running;
                end
            end
            if (press[BTN_CLR]) begin
                if (alarm_trigger)                 pulse_d.alarm_reset     = 1'b1;
                else if (mode_q == MODE_STOPWATCH) pulse_d.reset_stopwatch = 1'b1;
                else if (mode_q == MODE_TIMER)     pulse_d.reset_timer     = 1'b1;
            end
        end
        case (mode_d)
            MODE_SET_TIME:  lvl_d[0] = 1'b1;
            MODE_SET_ALARM: lvl_d[1] = 1'b1;
            MODE_STOPWATCH: lvl_d[2] = 1'b1;
            MODE_TIMER:     lvl_d[3] = 1'b1;
            MODE_SET_TIMER: lvl_d[4] = 1'b1;
            default: ;
        endcase
    end

    assign set_time_mode     = lvl_q[0];
    assign set_alarm_mode    = lvl_q[1];
    assign stopwatch_mode    = lvl_q[2];
    assign timer_mode        = lvl_q[3];
    assign set_timer_mode    = lvl_q[4];
    assign inc_hours         = pulse_q.inc_hours;
    assign inc_minutes       = pulse_q.inc_minutes;
    assign inc_seconds       = pulse_q.inc_seconds;
    assign inc_alarm_hours   = pulse_q.inc_alarm_hours;
    assign inc_alarm_minutes = pulse_q.inc_alarm_minutes;
    assign inc_timer_hours   = pulse_q.inc_timer_hours;
    assign inc_timer_minutes = pulse_q.inc_timer_minutes;
    assign inc_timer_seconds = pulse_q.inc_timer_seconds;
    assign start_stopwatch   = pulse_q.start_stopwatch;
    assign stop_stopwatch    = pulse_q.stop_stopwatch;
    assign reset_stopwatch   = pulse_q.reset_stopwatch;
    assign start_timer       = pulse_q.start_timer;
    assign stop_timer        = pulse_q.stop_timer;
    assign reset_timer       = pulse_q.reset_timer;
    assign alarm_reset       = pulse_q.alarm_reset;
    assign ui_mode           = mode_q;
    assign ui_field          = field_q;

endmodule
